// File: rtl/wrr_scheduler_pkg.sv
// wrr_scheduler_pkg: shared constants and types for the weighted round-robin
// scheduler that feeds the roundrobin output mux.
//   VCHANEL0..3 : channel index constants
//   fsm_t       : informational scheduler state (IDLE / SERVE)
//   CREDIT_W    : width of the per-burst credit counter
//   STAT_W      : width of the optional grant statistics counters
package wrr_scheduler_pkg;
  localparam int NUM_VC   = 4;
  localparam int CREDIT_W = 4;
  localparam int STAT_W   = 16;

  localparam logic [1:0] VCHANEL0 = 2'b00;
  localparam logic [1:0] VCHANEL1 = 2'b01;
  localparam logic [1:0] VCHANEL2 = 2'b10;
  localparam logic [1:0] VCHANEL3 = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } fsm_t;
endpackage

// File: rtl/wrr_scheduler_if.sv
// wrr_scheduler_if: FIFO-flag / pop / mux-select bundle between the scheduler
// and its surroundings.
//   enb, vc_nempty, out_full            : into the scheduler
//   pop_vchannel, arbiter, valid_channel : out of the scheduler
// master = scheduler side, slave = FIFO/mux (or bench) side.
interface wrr_scheduler_if;
  import wrr_scheduler_pkg::*;

  logic                enb;
  logic [NUM_VC-1:0]   vc_nempty;
  logic                out_full;
  logic [NUM_VC-1:0]   pop_vchannel;
  logic [1:0]          arbiter;
  logic [NUM_VC-1:0]   valid_channel;

  modport master (
    input  enb, vc_nempty, out_full,
    output pop_vchannel, arbiter, valid_channel
  );

  modport slave (
    output enb, vc_nempty, out_full,
    input  pop_vchannel, arbiter, valid_channel
  );
endinterface

// File: rtl/wrr_scheduler_next_sel.sv
// wrr_next_sel: combinational rotating-priority search.
//   cur   : current channel index
//   elig  : eligible-channel mask
//   nxt   : first eligible index in order cur+1, cur+2, cur+3, cur
//   found : high when any channel is eligible
module wrr_next_sel
  import wrr_scheduler_pkg::*;
(
  input  logic [1:0]        cur,
  input  logic [NUM_VC-1:0] elig,
  output logic [1:0]        nxt,
  output logic              found
);
  logic [1:0] idx;

  always_comb begin
    found = 1'b0;
    nxt   = cur;
    idx   = cur;
    // k runs 1..4 so cur itself is the last resort (offset 4 wraps to 0)
    for (int k = 1; k <= NUM_VC; k++) begin
      idx = cur + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        nxt   = idx;
      end
    end
  end
endmodule

// File: rtl/wrr_scheduler.sv
// wrr_scheduler: weighted round-robin pop scheduler for four VC FIFOs.
//   clk, rst (sync, active low)
//   bus.enb / bus.vc_nempty / bus.out_full : enable, FIFO flags, back-pressure
//   bus.pop_vchannel  : one-hot pop strobe, combinational with the grant
//   bus.arbiter       : registered index of last popped channel (mux select)
//   bus.valid_channel : registered one-hot copy of last cycle's pop
//   grant_cnt0..3     : saturating per-channel grant counters, only when the
//                       WRR_STATS_EN macro is defined
// Parameters W0..W3 set the burst weight per round (0 disables a channel).
module wrr_scheduler
  import wrr_scheduler_pkg::*;
#(
  parameter int unsigned W0 = 4,
  parameter int unsigned W1 = 3,
  parameter int unsigned W2 = 2,
  parameter int unsigned W3 = 1
) (
  input  logic clk,
  input  logic rst,
  wrr_scheduler_if.master bus
`ifdef WRR_STATS_EN
  ,
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1,
  output logic [STAT_W-1:0] grant_cnt2,
  output logic [STAT_W-1:0] grant_cnt3
`endif
);
  localparam logic [NUM_VC-1:0][CREDIT_W-1:0] WT =
    {CREDIT_W'(W3), CREDIT_W'(W2), CREDIT_W'(W1), CREDIT_W'(W0)};

  logic [1:0]          cur;
  logic [CREDIT_W-1:0] credit;
  fsm_t                fsm, fsm_nxt;

  logic [NUM_VC-1:0]   elig;
  logic                cont;
  logic [1:0]          sw_idx;
  logic                sw_found;
  logic [1:0]          cand;
  logic                grant;
  logic [NUM_VC-1:0]   pop;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_elig
    assign elig[i] = bus.vc_nempty[i] && (WT[i] != '0);
  end

  assign cont = elig[cur] && (credit != '0);

  wrr_next_sel u_next_sel (
    .cur   (cur),
    .elig  (elig),
    .nxt   (sw_idx),
    .found (sw_found)
  );

  assign cand  = cont ? cur : sw_idx;
  // rst in the grant term keeps pops quiet for the whole reset window
  assign grant = rst && bus.enb && !bus.out_full && (cont || sw_found);

  // state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm <= IDLE;
    end else begin
      fsm <= fsm_nxt;
    end
  end

  // next-state
  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    fsm_nxt = grant ? SERVE : IDLE;
      SERVE:   fsm_nxt = grant ? SERVE : IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    pop = '0;
    if (grant) pop[cand] = 1'b1;
  end

  assign bus.pop_vchannel = pop;

  // datapath: channel/credit bookkeeping and the registered mux controls
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur               <= VCHANEL0;
      credit            <= '0;
      bus.arbiter       <= VCHANEL0;
      bus.valid_channel <= '0;
    end else begin
      bus.valid_channel <= pop;
      if (grant) begin
        cur         <= cand;
        bus.arbiter <= cand;
        // switch or reload starts a fresh burst; leftover credit is dropped
        credit      <= cont ? credit - 1'b1 : WT[cand] - 1'b1;
      end
    end
  end

`ifdef WRR_STATS_EN
  logic [NUM_VC-1:0][STAT_W-1:0] cnt;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_stat
    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt[i] <= '0;
      end else if (pop[i] && (cnt[i] != '1)) begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign grant_cnt0 = cnt[0];
  assign grant_cnt1 = cnt[1];
  assign grant_cnt2 = cnt[2];
  assign grant_cnt3 = cnt[3];
`endif
endmodule

// File: tb/tb_wrr_scheduler.sv
// tb_wrr_scheduler: table-driven check of wrr_scheduler with a scoreboard for
// the registered mux controls. Weights 4,3,2,1.
module tb_wrr_scheduler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wrr_scheduler_if bus ();

`ifdef WRR_STATS_EN
  logic [15:0] gc0, gc1, gc2, gc3;
`endif

  wrr_scheduler #(.W0(4), .W1(3), .W2(2), .W3(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef WRR_STATS_EN
    ,
    .grant_cnt0 (gc0),
    .grant_cnt1 (gc1),
    .grant_cnt2 (gc2),
    .grant_cnt3 (gc3)
`endif
  );

  typedef struct {
    logic [3:0] vc;
    logic       full;
    logic       en;
    logic [3:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0] v;
    logic [1:0] a;
    logic       chk_a;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // ch < 0 means no pop expected
  function automatic void addc(input logic [3:0] vc, input logic full,
                               input logic en, input int ch);
    vec_t v;
    v.vc   = vc;
    v.full = full;
    v.en   = en;
    v.exp  = (ch < 0) ? 4'b0000 : 4'(1 << ch);
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check the combinational pop, queue the
  // expected registered outputs, then compare them just after the edge.
  task automatic step(input logic [3:0] vc, input logic full, input logic en,
                      input logic r, input logic [3:0] exp);
    sb_t e;
    @(negedge clk);
    bus.vc_nempty = vc;
    bus.out_full  = full;
    bus.enb       = en;
    rst           = r;
    #1 chk("pop_vchannel", 16'(bus.pop_vchannel), 16'(exp));
    e.v     = exp;
    e.a     = r ? idx_of(exp) : 2'd0;
    e.chk_a = !r || (exp != 4'b0000);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("valid_channel", 16'(bus.valid_channel), 16'(e.v));
    if (e.chk_a) chk("arbiter", 16'(bus.arbiter), 16'(e.a));
  endtask

  initial begin
    int pa[20]  = '{1,1,1,2,2,3,0,0,0,0, 1,1,1,2,2,3,0,0,0,0};
    int pb1[8]  = '{1,1,1,2,2,3,0,0};
    int pb2[8]  = '{0,0,1,1,1,2,2,3};
    int pc1[5]  = '{0,0,0,0,1};
    int pc2[7]  = '{2,2,3,0,0,0,0};
    int pc3[4]  = '{1,1,1,2};
    int pe[3]   = '{2,3,0};
    int pg1[6]  = '{0,0,0,0,1,1};
    int pg2[4]  = '{1,1,1,2};

    bus.vc_nempty = 4'h0;
    bus.out_full  = 1'b0;
    bus.enb       = 1'b0;
    rst           = 1'b0;

    // reset state, and pop forced low while rst is low even with demand
    repeat (3) @(posedge clk);
    #1;
    chk("reset arbiter", 16'(bus.arbiter), 16'h0);
    chk("reset valid_channel", 16'(bus.valid_channel), 16'h0);
    bus.vc_nempty = 4'hF;
    bus.enb       = 1'b1;
    #1 chk("reset pop", 16'(bus.pop_vchannel), 16'h0);
    @(posedge clk);
    #1 chk("reset valid hold", 16'(bus.valid_channel), 16'h0);
`ifdef WRR_STATS_EN
    chk("reset grant_cnt0", gc0, 16'd0);
`endif

    // all channels busy: after reset the search starts at channel 1
    foreach (pa[k]) addc(4'hF, 1'b0, 1'b1, pa[k]);
    // out_full for 3 cycles after the 2nd channel-0 grant
    foreach (pb1[k]) addc(4'hF, 1'b0, 1'b1, pb1[k]);
    repeat (3) addc(4'hF, 1'b1, 1'b1, -1);
    foreach (pb2[k]) addc(4'hF, 1'b0, 1'b1, pb2[k]);
    // channel 1 empties after its first grant, then returns with fresh credit
    foreach (pc1[k]) addc(4'hF, 1'b0, 1'b1, pc1[k]);
    foreach (pc2[k]) addc(4'b1101, 1'b0, 1'b1, pc2[k]);
    foreach (pc3[k]) addc(4'hF, 1'b0, 1'b1, pc3[k]);
    // only channel 2: back-to-back pops across credit reloads
    repeat (6) addc(4'b0100, 1'b0, 1'b1, 2);
    // enb low behaves like a stall, burst resumes afterwards
    repeat (2) addc(4'hF, 1'b0, 1'b0, -1);
    foreach (pe[k]) addc(4'hF, 1'b0, 1'b1, pe[k]);
    // nothing eligible, then a lone weight-1 channel reloads every grant
    repeat (2) addc(4'h0, 1'b0, 1'b1, -1);
    repeat (2) addc(4'b1000, 1'b0, 1'b1, 3);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].vc, tbl[i].full, tbl[i].en, 1'b1, tbl[i].exp);
`ifdef WRR_STATS_EN
      if (i == 19) begin
        chk("grant_cnt0", gc0, 16'd8);
        chk("grant_cnt1", gc1, 16'd6);
        chk("grant_cnt2", gc2, 16'd4);
        chk("grant_cnt3", gc3, 16'd2);
      end
`endif
    end

    // reset mid-burst on channel 1, then a fresh 3-grant burst on channel 1
    foreach (pg1[k]) step(4'hF, 1'b0, 1'b1, 1'b1, 4'(1 << pg1[k]));
    step(4'hF, 1'b0, 1'b1, 1'b0, 4'b0000);
    foreach (pg2[k]) step(4'hF, 1'b0, 1'b1, 1'b1, 4'(1 << pg2[k]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/wrr_scheduler.md
# wrr_scheduler

Weighted round-robin scheduler sitting directly upstream of the `roundrobin` output mux. It watches the non-empty flags of the four virtual-channel FIFOs and issues one-hot pop strobes to them. It then drives the registered `arbiter` select and `valid_channel` qualifier so the mux forwards the popped word on the following cycle. Each channel gets a configurable burst weight per round; the scheduler is work-conserving and stalls on downstream back-pressure.

## Interface
- `W0`, default 4: burst weight of channel 0 (0–15; 0 means the channel is never served)
- `W1`, default 3: burst weight of channel 1
- `W2`, default 2: burst weight of channel 2
- `W3`, default 1: burst weight of channel 3
- `clk` input 1: single clock; all state updates on its rising edge
- `rst` input 1: synchronous, active-low reset
- `enb` input 1: block enable; low means no grants, state held
- `vc_nempty` input 4: bit i high means FIFO i holds at least one word
- `out_full` input 1: downstream cannot accept a word this cycle
- `pop_vchannel` output 4: one-hot pop strobe to the FIFOs, combinational, same cycle as the grant
- `arbiter` output 2: registered index of the channel popped in the previous cycle; drives the mux select
- `valid_channel` output 4: registered one-hot copy of the previous cycle's pop; all zero when nothing was popped
- `grant_cnt0`..`grant_cnt3` output 16 each: present only with `WRR_STATS_EN`

## Operation
- State registers:
  - `cur`, 2 bits: channel being served
  - `credit`, 4 bits: grants remaining in the current burst
  - `fsm`: IDLE or SERVE
- A channel is eligible when its `vc_nempty` bit is high and its weight is nonzero.
- Continue condition: `cur` is eligible and `credit != 0`.
  - If it holds, the candidate is `cur`.
  - Otherwise the candidate is the first eligible channel searching `cur+1, cur+2, cur+3, cur`, wrapping modulo 4.
- A grant fires when `enb` is high, `out_full` is low, and a candidate exists. On a grant:
  - `pop_vchannel[candidate]` goes high.
  - `cur` is loaded with the candidate.
  - On continue, `credit` is decremented; on a switch or reload, `credit` is loaded with W[candidate]−1.
  - `fsm` moves to SERVE.
- With no grant, `pop_vchannel` is 0 and `fsm` moves to IDLE. `cur` and `credit` are held.
- A burst cut short by an empty FIFO forfeits its remaining credit. No deficit carries over.
- If the only eligible channel is `cur` with `credit == 0`, `credit` is reloaded and `cur` is served again with no bubble.
- FSM transitions:
  - IDLE→SERVE on a grant.
  - SERVE→IDLE on a cycle without a grant.
  - SERVE→SERVE otherwise.
  - The FSM is informational and drives no outputs beyond those listed above.
- If all weights are 0, no grant ever fires.
- The scheduler never drives more than one `pop_vchannel` bit high.

## Timing
- Reset state, applied at a clock edge with `rst` low:
  - `cur`=0, `credit`=0, `fsm`=IDLE.
  - `arbiter`=0, `valid_channel`=0, all `grant_cnt`=0.
  - `pop_vchannel` is forced to 0 while `rst` is low.
- Pop-to-select latency is 1 cycle. This matches the FIFOs' synchronous read: data, `arbiter` and `valid_channel` arrive at the mux together.
- Throughput: one grant per cycle while eligible data exists and `out_full` is low. Channel switches cost 0 cycles.
- `out_full` is sampled combinationally. In a stalled cycle there is no pop, `credit` is held, and the next `valid_channel` is 0.
- `enb` low behaves like a stall.
- Reset asserted mid-burst: from the next edge, all outputs are at their reset values. After release, the first grant goes to the first eligible channel searched from channel 1, wrapping, with fresh credit.

## Configuration
- `WRR_STATS_EN` defined:
  - Adds four 16-bit saturating grant counters, `grant_cnt0`..`grant_cnt3`.
  - The counter of the granted channel increments on each grant.
  - Counters are cleared by reset and hold at 16'hFFFF.
- `WRR_STATS_EN` undefined: the counters and their ports are absent. Scheduling behaviour is identical either way.

## Structure
- Shared package holds:
  - channel index constants VCHANEL0..VCHANEL3 (2'b00..2'b11)
  - FSM state encodings IDLE and SERVE
  - credit width (4)
  - stats counter width (16)
- Natural sub-module `wrr_next_sel`: combinational rotating priority search taking `cur` and the eligible mask, returning the next index and a found flag.

## Test plan
- All four channels non-empty, `out_full`=0, weights 4,3,2,1 → pops 0,0,0,0,1,1,1,2,2,3 repeating. `arbiter` shows the same sequence delayed one cycle.
- Only channel 2 non-empty → `pop_vchannel`=4'b0100 every cycle. `credit` reloads every 2 grants with no gaps.
- All channels non-empty, `out_full` high for 3 cycles after the 2nd channel-0 grant → no pops and `valid_channel`=0 during the stall. After release, 2 more channel-0 pops, then channel 1.
- Channel 1 `vc_nempty` drops after its first grant → the next cycle pops channel 2. Channel 1's leftover credit is not carried into the next round.
- `rst` low mid-burst on channel 1 → next edge: `arbiter`=0, `valid_channel`=0, `pop_vchannel`=0. After release with all channels non-empty, the first pop is channel 1 with 3 consecutive grants.
- With `WRR_STATS_EN`, 20 grants in the all-channels-non-empty scenario → `grant_cnt0`..`grant_cnt3` read 8,6,4,2.
